usb_rx_ctrl: RTL and testbench

Packet-level receive controller placed after the nibble-to-byte receive front end on the USB-side link.
- Arms and disarms the front end through its fire input.
- Frames incoming bytes into packets: header, type, length, payload, checksum.
- Writes payload into an external buffer RAM.
- Reports completion or a classified error to the command layer.

---
 rtl/usb_pkg.sv | 25 ++
 rtl/usb_rx_timer.sv | 28 ++
 rtl/usb_rx_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_usb_rx_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared definitions for the USB-side receive path.
package usb_pkg;

  localparam int unsigned CSUM_W        = 8;
  localparam logic [7:0]  HEAD_BYTE_DEF = 8'h55;

  localparam logic [1:0] ERR_TRUNC = 2'd0;
  localparam logic [1:0] ERR_HEAD  = 2'd1;
  localparam logic [1:0] ERR_LEN   = 2'd2;
  localparam logic [1:0] ERR_CSUM  = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ARM,
    ST_HEAD,
    ST_TYPE,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/usb_rx_timer.sv
// Inter-byte idle counter: cleared by clr, flags expiry after TIMEOUT idle cycles.
module usb_rx_timer #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Expiry is flagged one count early so the resulting error pulse lands
  // exactly TIMEOUT cycles after the clearing byte.
  assign expire = !clr && (cnt == CW'(TIMEOUT - 2));

  // Idle count, held once expired until the owner clears it.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (!expire) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/usb_rx_ctrl.sv
// Packet-level receive controller: frames header/type/len/payload/checksum,
// writes payload to the buffer RAM and reports done or a classified error.
module usb_rx_ctrl
  import usb_pkg::*;
#(
  parameter int unsigned MAX_LEN   = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter logic [7:0]  HEAD_BYTE = HEAD_BYTE_DEF,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              link_fire,
  output logic              rxf_fire,
  input  logic [7:0]        rx_data,
  input  logic              rx_vld,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [7:0]        buf_wdata,
  output logic [7:0]        pkt_type,
  output logic [7:0]        pkt_len,
  output logic              pkt_done,
  output logic              pkt_err,
  output logic [1:0]        err_code,
  output logic              busy
);

  localparam logic [7:0] MAX_B = 8'(MAX_LEN);

  state_t state, state_d;

  logic [CSUM_W-1:0] csum, csum_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        cnt, cnt_d;
  logic [7:0]        type_q, type_d;
  logic [7:0]        pkt_type_d, pkt_len_d;
  logic [1:0]        err_d;
  logic              we_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [7:0]        wdata_d;

  logic in_pkt, armed, expire, abort;

  assign in_pkt   = state inside {ST_HEAD, ST_TYPE, ST_LEN, ST_DATA, ST_CSUM};
  assign armed    = in_pkt || (state == ST_ARM);
  assign rxf_fire = link_fire && armed;
  assign busy     = !(state inside {ST_IDLE, ST_ARM});
  assign pkt_done = (state == ST_DONE);
  assign pkt_err  = (state == ST_ERR);
  assign abort    = !link_fire || expire;

  usb_rx_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (rx_vld || !in_pkt),
    .expire (expire)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      csum      <= '0;
      len_q     <= '0;
      cnt       <= '0;
      type_q    <= '0;
      pkt_type  <= '0;
      pkt_len   <= '0;
      err_code  <= '0;
      buf_we    <= 1'b0;
      buf_waddr <= '0;
      buf_wdata <= '0;
    end else begin
      state     <= state_d;
      csum      <= csum_d;
      len_q     <= len_d;
      cnt       <= cnt_d;
      type_q    <= type_d;
      pkt_type  <= pkt_type_d;
      pkt_len   <= pkt_len_d;
      err_code  <= err_d;
      buf_we    <= we_d;
      buf_waddr <= waddr_d;
      buf_wdata <= wdata_d;
    end
  end

  // Next-state and datapath updates; a byte strobe always wins over abort.
  always_comb begin
    state_d    = state;
    csum_d     = csum;
    len_d      = len_q;
    cnt_d      = cnt;
    type_d     = type_q;
    pkt_type_d = pkt_type;
    pkt_len_d  = pkt_len;
    err_d      = err_code;
    we_d       = 1'b0;
    waddr_d    = buf_waddr;
    wdata_d    = buf_wdata;

    case (state)
      ST_IDLE: if (enable) state_d = ST_ARM;
      ST_ARM, ST_HEAD: begin
        if (rx_vld) begin
          if (rx_data == HEAD_BYTE) begin
            state_d = ST_TYPE;
          end else begin
            state_d = ST_ERR;
            err_d   = ERR_HEAD;
          end
        end else if (state == ST_ARM) begin
          if (!enable) state_d = ST_IDLE;
        end else if (abort) begin
          state_d = ST_ERR;
          err_d   = ERR_TRUNC;
        end
      end
      ST_TYPE: begin
        if (rx_vld) begin
          type_d  = rx_data;
          csum_d  = rx_data;
          state_d = ST_LEN;
        end else if (abort) begin
          state_d = ST_ERR;
          err_d   = ERR_TRUNC;
        end
      end
      ST_LEN: begin
        if (rx_vld) begin
          if (rx_data == 8'd0 || rx_data > MAX_B) begin
            state_d = ST_ERR;
            err_d   = ERR_LEN;
          end else begin
            len_d   = rx_data;
            csum_d  = csum + rx_data;
            cnt_d   = '0;
            state_d = ST_DATA;
          end
        end else if (abort) begin
          state_d = ST_ERR;
          err_d   = ERR_TRUNC;
        end
      end
      ST_DATA: begin
        if (rx_vld) begin
          we_d    = 1'b1;
          waddr_d = cnt[ADDR_W-1:0];
          wdata_d = rx_data;
          csum_d  = csum + rx_data;
          cnt_d   = cnt + 8'd1;
          if (cnt_d == len_q) state_d = ST_CSUM;
        end else if (abort) begin
          state_d = ST_ERR;
          err_d   = ERR_TRUNC;
        end
      end
      ST_CSUM: begin
        if (rx_vld) begin
          if (rx_data == csum) begin
            pkt_type_d = type_q;
            pkt_len_d  = len_q;
            state_d    = ST_DONE;
          end else begin
            state_d = ST_ERR;
            err_d   = ERR_CSUM;
          end
        end else if (abort) begin
          state_d = ST_ERR;
          err_d   = ERR_TRUNC;
        end
      end
      ST_DONE, ST_ERR: state_d = ST_DRAIN;
      ST_DRAIN: if (!link_fire) state_d = enable ? ST_ARM : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Self-checking bench for usb_rx_ctrl: packet-level reference model with a
// per-cycle scoreboard of expected writes, done/err pulses and held outputs.
module tb_usb_rx_ctrl;

  localparam int unsigned MAX_LEN = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned TIMEOUT = 40;
  localparam logic [7:0]  HB      = 8'h55;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic              link_fire = 1'b0;
  logic              rx_vld = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rxf_fire, buf_we, pkt_done, pkt_err, busy;
  logic [ADDR_W-1:0] buf_waddr;
  logic [7:0]        buf_wdata, pkt_type, pkt_len;
  logic [1:0]        err_code;

  usb_rx_ctrl #(.MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W), .HEAD_BYTE(HB), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .link_fire(link_fire), .rxf_fire(rxf_fire),
    .rx_data(rx_data), .rx_vld(rx_vld), .buf_we(buf_we), .buf_waddr(buf_waddr),
    .buf_wdata(buf_wdata), .pkt_type(pkt_type), .pkt_len(pkt_len), .pkt_done(pkt_done),
    .pkt_err(pkt_err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  // Expected events keyed by the cycle in which they must be visible.
  logic [ADDR_W+7:0] exp_wr[int];
  logic [15:0]       exp_done[int];
  logic [1:0]        exp_err[int];
  bit                exp_rst[int];
  logic [7:0]        ref_type = '0;
  logic [7:0]        ref_len  = '0;
  logic [1:0]        ref_code = '0;
  bit                chk_en = 1'b0;
  logic [7:0]        mem[0:31];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // Per-cycle comparison against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (exp_rst.exists(cyc)) begin ref_type = '0; ref_len = '0; ref_code = '0; end
        if (exp_done.exists(cyc)) {ref_type, ref_len} = exp_done[cyc];
        if (exp_err.exists(cyc)) ref_code = exp_err[cyc];
        check("buf_we", buf_we, exp_wr.exists(cyc));
        if (exp_wr.exists(cyc) && buf_we) check("buf_addr_data", {buf_waddr, buf_wdata}, exp_wr[cyc]);
        if (buf_we) mem[buf_waddr] = buf_wdata;
        check("pkt_done", pkt_done, exp_done.exists(cyc));
        check("pkt_err", pkt_err, exp_err.exists(cyc));
        check("held_type_len_code", {pkt_type, pkt_len, err_code}, {ref_type, ref_len, ref_code});
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  function automatic logic [7:0] sum8(input logic [7:0] q[$], input int lo, input int hi);
    logic [7:0] s = '0;
    for (int i = lo; i <= hi; i++) s += q[i];
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] b, output int c);
    rx_data = b;
    rx_vld  = 1'b1;
    c       = cyc;
    tick();
    rx_vld  = 1'b0;
  endtask

  // Sends the first n_send bytes of b and posts the outcome the packet rules
  // dictate. trunc: 0 none, 1 stall until timeout, 2 drop link after the bytes.
  task automatic run_pkt(input logic [7:0] b[$], input int n_send, input int trunc, input int gmax,
                         input int long_at, input int en_drop_at, input bit drop_on_last);
    int c, s, o;
    int len;
    bit hdr_ok, len_ok;
    hdr_ok = (b[0] == HB);
    len    = (b.size() > 2) ? int'(b[2]) : 0;
    len_ok = (len != 0) && (len <= MAX_LEN);
    link_fire = 1'b1;
    tick();
    @(negedge clk);
    check("armed_rxf_busy", {busy, rxf_fire}, 2'b01);
    @(posedge clk); #1;
    o = -1;
    s = cyc;
    for (int i = 0; i < n_send; i++) begin
      repeat ((i == long_at) ? int'(TIMEOUT) - 2 : $urandom_range(0, gmax)) tick();
      if (i == en_drop_at) enable = 1'b0;
      if (drop_on_last && i == n_send - 1) link_fire = 1'b0;
      strobe(b[i], c);
      s = c;
      if (i == 0 && !hdr_ok) begin
        exp_err[c+1] = 2'd1; o = c + 1;
      end else if (i == 2 && !len_ok) begin
        exp_err[c+1] = 2'd2; o = c + 1;
      end else if (i >= 3 && i < 3 + len) begin
        exp_wr[c+1] = {ADDR_W'(i - 3), b[i]};
      end else if (i == 3 + len) begin
        if (b[i] == sum8(b, 1, 2 + len)) exp_done[c+1] = {b[1], b[2]};
        else exp_err[c+1] = 2'd3;
        o = c + 1;
      end
    end
    if (trunc == 1) begin
      o = s + int'(TIMEOUT);
      exp_err[o] = 2'd0;
    end else if (trunc == 2) begin
      repeat ($urandom_range(0, 4)) tick();
      link_fire = 1'b0;
      o = cyc + 1;
      exp_err[o] = 2'd0;
    end
    while (cyc <= o) tick();
    if (link_fire) begin
      @(negedge clk);
      check("drain_rxf_busy", {busy, rxf_fire}, 2'b10);
      @(posedge clk); #1;
      link_fire = 1'b0;
    end
    tick();
    tick();
  endtask

  task automatic build(input int kind, output logic [7:0] b[$], output int n_send, output int trunc);
    logic [7:0] len, t;
    b = {};
    if (kind == 2) len = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255));
    else len = 8'($urandom_range(1, MAX_LEN));
    if (kind == 1) begin
      do t = 8'($urandom); while (t == HB);
      b.push_back(t);
    end else begin
      b.push_back(HB);
    end
    b.push_back(8'($urandom));
    b.push_back(len);
    if (kind != 2) begin
      for (int i = 0; i < int'(len); i++) b.push_back(8'($urandom));
      b.push_back(sum8(b, 1, 2 + int'(len)) + ((kind == 3) ? 8'($urandom_range(1, 255)) : 8'h00));
    end
    n_send = b.size();
    trunc  = 0;
    if (kind == 1) n_send = 1;
    if (kind == 4 || kind == 5) begin
      n_send = $urandom_range(1, 3 + int'(len));
      trunc  = (kind == 4) ? 1 : 2;
    end
  endtask

  initial begin
    logic [7:0] q[$];
    int n, tr, c;

    repeat (2) tick();
    @(negedge clk);
    check("reset_outputs",
          {buf_we, buf_waddr, buf_wdata, pkt_type, pkt_len, pkt_done, pkt_err, err_code, busy, rxf_fire},
          '0);
    @(posedge clk); #1;
    chk_en = 1'b1;
    rst    = 1'b0;
    enable = 1'b1;
    tick(); tick();

    // Reference good packet, back-to-back bytes.
    q = {HB, 8'h01, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h35};
    check("model_csum", sum8(q, 1, 5), 8'h35);
    run_pkt(q, 7, 0, 0, -1, -1, 1'b0);
    check("good_type_len", {pkt_type, pkt_len}, 16'h0103);
    check("good_buf", {mem[0], mem[1], mem[2]}, 24'hAABBCC);

    // Bad header.
    q = {8'h5A};
    run_pkt(q, 1, 0, 0, -1, -1, 1'b0);
    check("bad_head_code", err_code, 2'd1);

    // Bad lengths; pkt_len must keep 03.
    q = {HB, 8'h02, 8'h00};
    run_pkt(q, 3, 0, 0, -1, -1, 1'b0);
    check("bad_len0", {pkt_len, err_code}, {8'h03, 2'd2});
    q = {HB, 8'h02, 8'h21};
    run_pkt(q, 3, 0, 0, -1, -1, 1'b0);
    check("bad_len33", {pkt_len, err_code}, {8'h03, 2'd2});

    // Checksum off by one.
    q = {HB, 8'h01, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h36};
    run_pkt(q, 7, 0, 0, -1, -1, 1'b0);
    check("csum_code", err_code, 2'd3);

    // Truncation by timeout, then by link drop, after two payload bytes.
    q = {HB, 8'h01, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h35};
    run_pkt(q, 5, 1, 0, -1, -1, 1'b0);
    check("timeout_code", err_code, 2'd0);
    q = {HB, 8'h09, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h3D};
    run_pkt(q, 7, 0, 1, -1, -1, 1'b0);
    run_pkt(q, 5, 2, 0, -1, -1, 1'b0);
    check("link_drop_code", err_code, 2'd0);

    // Longest tolerated gap, and checksum byte coinciding with link drop.
    run_pkt(q, 7, 0, 1, 4, -1, 1'b0);
    run_pkt(q, 7, 0, 0, -1, -1, 1'b1);
    check("drop_on_csum_done", {pkt_type, err_code}, {8'h09, 2'd0});

    // Enable falls mid-payload: completes, then parks in IDLE.
    run_pkt(q, 7, 0, 1, -1, 4, 1'b0);
    link_fire = 1'b1;
    tick();
    @(negedge clk);
    check("disabled_idle", {busy, rxf_fire}, 2'b00);
    @(posedge clk); #1;
    enable = 1'b1;
    link_fire = 1'b0;
    tick(); tick();

    // Randomised packets of every kind.
    for (int k = 0; k < 120; k++) begin
      build($urandom_range(0, 5), q, n, tr);
      run_pkt(q, n, tr, 2, -1, -1, 1'b0);
    end

    // Reset mid-payload, with a byte strobed in the reset cycle.
    link_fire = 1'b1;
    tick();
    strobe(HB, c);
    strobe(8'h07, c);
    strobe(8'h03, c);
    strobe(8'hAA, c);
    exp_wr[c+1] = {ADDR_W'(0), 8'hAA};
    rst = 1'b1;
    strobe(8'hBB, c);
    exp_rst[c+1] = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_mid_outputs",
          {buf_we, buf_waddr, buf_wdata, pkt_type, pkt_len, pkt_done, pkt_err, err_code, busy, rxf_fire},
          '0);
    @(posedge clk); #1;
    link_fire = 1'b0;
    tick(); tick();
    q = {HB, 8'h01, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h35};
    run_pkt(q, 7, 0, 1, -1, -1, 1'b0);
    check("recover_type_len", {pkt_type, pkt_len}, 16'h0103);

    repeat (4) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
